// File: rtl/xadc_drp_scheduler.sv
// XADC DRP owner: per-EOS voltage/current sample reads plus a shared host config port.
// Optional XADC_DRP_TIMEOUT_EN abandons DRP transactions that never see xadc_drdy.
module xadc_drp_scheduler #(
  parameter int         DATA_WIDTH     = 16,
  parameter logic [6:0] VOLTAGE_ADDR   = 7'h1c,
  parameter logic [6:0] CURRENT_ADDR   = 7'h14,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                  xadc_dclk,
  input  logic                  xadc_reset,
  output logic [6:0]            xadc_daddr,
  output logic                  xadc_den,
  output logic                  xadc_dwe,
  output logic [DATA_WIDTH-1:0] xadc_di,
  input  logic                  xadc_drdy,
  input  logic [DATA_WIDTH-1:0] xadc_do,
  input  logic                  xadc_eos,
  output logic [DATA_WIDTH-1:0] voltage_channel_tdata,
  output logic                  voltage_channel_tvalid,
  input  logic                  voltage_channel_tready,
  output logic [DATA_WIDTH-1:0] current_monitor_channel_tdata,
  output logic                  current_monitor_channel_tvalid,
  input  logic                  current_monitor_channel_tready,
  input  logic                  cfg_req,
  input  logic                  cfg_we,
  input  logic [6:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_ack,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  sample_dropped
);

  typedef enum logic [2:0] {
    IDLE, RD_VOLT, WAIT_VOLT, RD_CURR,
    WAIT_CURR, CFG_ISSUE, CFG_WAIT
  } state_t;

  state_t state;
  logic   eos_pending;
  logic   cfg_first;
  logic   cfg_we_q;
  logic   tmo;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting = (state == WAIT_VOLT) ||
                   (state == WAIT_CURR) ||
                   (state == CFG_WAIT);
  assign tmo = waiting && !xadc_drdy &&
               (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counter restarts in each issue cycle, so it is zero on WAIT entry
  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) begin
      tmo_cnt <= '0;
    end else if (!waiting) begin
      tmo_cnt <= '0;
    end else if (!tmo) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  logic go_cfg, go_volt, enter_volt;
  logic eos_miss, samp_tmo, drop;
  logic v_cap, v_room, c_cap, c_room;

  // A fresh EOS seen in IDLE holds off the host for one cycle so it can latch
  assign go_cfg = cfg_req && !cfg_ack &&
                  !(xadc_eos && !eos_pending) &&
                  (cfg_first || !eos_pending);
  assign go_volt    = eos_pending && !go_cfg;
  assign enter_volt = (state == IDLE) && go_volt;

  assign v_cap  = (state == WAIT_VOLT) && xadc_drdy;
  assign v_room = !voltage_channel_tvalid ||
                  voltage_channel_tready;
  assign c_cap  = (state == WAIT_CURR) && xadc_drdy;
  assign c_room = !current_monitor_channel_tvalid ||
                  current_monitor_channel_tready;

  assign eos_miss = xadc_eos && eos_pending && !enter_volt;
  assign samp_tmo = tmo && ((state == WAIT_VOLT) ||
                            (state == WAIT_CURR));
  assign drop = eos_miss || (v_cap && !v_room) ||
                (c_cap && !c_room) || samp_tmo;

  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) begin
      state                          <= IDLE;
      eos_pending                    <= 1'b0;
      cfg_first                      <= 1'b0;
      cfg_we_q                       <= 1'b0;
      xadc_daddr                     <= '0;
      xadc_den                       <= 1'b0;
      xadc_dwe                       <= 1'b0;
      xadc_di                        <= '0;
      voltage_channel_tdata          <= '0;
      voltage_channel_tvalid         <= 1'b0;
      current_monitor_channel_tdata  <= '0;
      current_monitor_channel_tvalid <= 1'b0;
      cfg_ack                        <= 1'b0;
      cfg_rdata                      <= '0;
      sample_dropped                 <= 1'b0;
    end else begin
      xadc_den       <= 1'b0;
      xadc_dwe       <= 1'b0;
      cfg_ack        <= 1'b0;
      sample_dropped <= drop;

      if (xadc_eos) begin
        eos_pending <= 1'b1;
      end else if (enter_volt) begin
        eos_pending <= 1'b0;
      end

      if (v_cap && v_room) begin
        voltage_channel_tdata  <= xadc_do;
        voltage_channel_tvalid <= 1'b1;
      end else if (voltage_channel_tready) begin
        voltage_channel_tvalid <= 1'b0;
      end

      if (c_cap && c_room) begin
        current_monitor_channel_tdata  <= xadc_do;
        current_monitor_channel_tvalid <= 1'b1;
      end else if (current_monitor_channel_tready) begin
        current_monitor_channel_tvalid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (go_cfg) begin
            state      <= CFG_ISSUE;
            xadc_den   <= 1'b1;
            xadc_dwe   <= cfg_we;
            xadc_daddr <= cfg_addr;
            xadc_di    <= cfg_wdata;
            cfg_we_q   <= cfg_we;
            cfg_first  <= 1'b0;
          end else if (go_volt) begin
            state      <= RD_VOLT;
            xadc_den   <= 1'b1;
            xadc_daddr <= VOLTAGE_ADDR;
          end
        end
        RD_VOLT: state <= WAIT_VOLT;
        WAIT_VOLT: begin
          if (xadc_drdy || tmo) begin
            state      <= RD_CURR;
            xadc_den   <= 1'b1;
            xadc_daddr <= CURRENT_ADDR;
          end
        end
        RD_CURR: state <= WAIT_CURR;
        WAIT_CURR: begin
          if (xadc_drdy || tmo) begin
            state     <= IDLE;
            cfg_first <= cfg_req;
          end
        end
        CFG_ISSUE: state <= CFG_WAIT;
        CFG_WAIT: begin
          if (xadc_drdy) begin
            state   <= IDLE;
            cfg_ack <= 1'b1;
            if (!cfg_we_q) cfg_rdata <= xadc_do;
          end else if (tmo) begin
            state     <= IDLE;
            cfg_ack   <= 1'b1;
            cfg_rdata <= DATA_WIDTH'(16'hdead);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Directed bench for xadc_drp_scheduler with a DRP BFM answering 3 cycles after den.
// BFM read data is {bfm_hi, 1'b0, daddr} so every expected value is known up front.
module tb_xadc_drp_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] di;
  logic        drdy;
  logic [15:0] xdo;
  logic        eos;
  logic [15:0] v_tdata, c_tdata;
  logic        v_tvalid, c_tvalid;
  logic        v_tready, c_tready;
  logic        cfg_req, cfg_we, cfg_ack;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_wdata, cfg_rdata;
  logic        dropped;

  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;
  int bfm_cnt = 0;
  logic       bfm_on = 1'b1;
  logic [7:0] bfm_hi = 8'h00;
  logic [6:0] bfm_addr = 7'h0;

  xadc_drp_scheduler dut (
    .xadc_dclk                      (clk),
    .xadc_reset                     (rst),
    .xadc_daddr                     (daddr),
    .xadc_den                       (den),
    .xadc_dwe                       (dwe),
    .xadc_di                        (di),
    .xadc_drdy                      (drdy),
    .xadc_do                        (xdo),
    .xadc_eos                       (eos),
    .voltage_channel_tdata          (v_tdata),
    .voltage_channel_tvalid         (v_tvalid),
    .voltage_channel_tready         (v_tready),
    .current_monitor_channel_tdata  (c_tdata),
    .current_monitor_channel_tvalid (c_tvalid),
    .current_monitor_channel_tready (c_tready),
    .cfg_req                        (cfg_req),
    .cfg_we                         (cfg_we),
    .cfg_addr                       (cfg_addr),
    .cfg_wdata                      (cfg_wdata),
    .cfg_ack                        (cfg_ack),
    .cfg_rdata                      (cfg_rdata),
    .sample_dropped                 (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    drdy = 1'b0;
    xdo  = 16'h0;
    forever begin
      @(negedge clk);
      drdy = 1'b0;
      if (bfm_cnt != 0) begin
        bfm_cnt = bfm_cnt - 1;
        if (bfm_cnt == 0) begin
          drdy = 1'b1;
          xdo  = {bfm_hi, 1'b0, bfm_addr};
        end
      end
      if (den === 1'b1 && bfm_on) begin
        bfm_cnt  = 3;
        bfm_addr = daddr;
      end
    end
  end

  always @(posedge clk) begin
    if (dropped === 1'b1) drop_cnt = drop_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_eos();
    eos = 1'b1;
    step(1);
    eos = 1'b0;
  endtask

  task automatic wait_den(input string tag, input logic [6:0] addr);
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1);
      seen = (den === 1'b1);
    end
    chk({tag, "_den"}, seen, 1'b1);
    chk({tag, "_addr"}, daddr, addr);
  endtask

  task automatic wait_v(input string tag, input logic [15:0] data);
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1);
      seen = (v_tvalid === 1'b1);
    end
    chk({tag, "_vvalid"}, seen, 1'b1);
    chk({tag, "_vdata"}, v_tdata, data);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_den"}, den, 1'b0);
    chk({tag, "_dwe"}, dwe, 1'b0);
    chk({tag, "_daddr"}, daddr, 7'h0);
    chk({tag, "_di"}, di, 16'h0);
    chk({tag, "_vvalid"}, v_tvalid, 1'b0);
    chk({tag, "_vdata"}, v_tdata, 16'h0);
    chk({tag, "_cvalid"}, c_tvalid, 1'b0);
    chk({tag, "_cdata"}, c_tdata, 16'h0);
    chk({tag, "_ack"}, cfg_ack, 1'b0);
    chk({tag, "_rdata"}, cfg_rdata, 16'h0);
    chk({tag, "_drop"}, dropped, 1'b0);
  endtask

  initial begin
    int vcount;
    int dcount;
    logic ack_seen;
    rst = 1'b1;
    eos = 1'b0;
    v_tready = 1'b1;
    c_tready = 1'b1;
    cfg_req = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 7'h0;
    cfg_wdata = 16'h0;
    step(3);
    chk_reset("rst");
    rst = 1'b0;
    step(2);

    // Basic sample sequence with exact timing
    bfm_hi = 8'hA0;
    drop_cnt = 0;
    pulse_eos();
    chk("t1_idle_den", den, 1'b0);
    step(1);
    chk("t1_vden", den, 1'b1);
    chk("t1_vaddr", daddr, 7'h1c);
    chk("t1_vdwe", dwe, 1'b0);
    step(1);
    chk("t1_den_off", den, 1'b0);
    chk("t1_addr_hold", daddr, 7'h1c);
    step(3);
    chk("t1_vvalid", v_tvalid, 1'b1);
    chk("t1_vdata", v_tdata, 16'hA01C);
    chk("t1_cden", den, 1'b1);
    chk("t1_caddr", daddr, 7'h14);
    step(1);
    chk("t1_vpop", v_tvalid, 1'b0);
    step(3);
    chk("t1_cvalid", c_tvalid, 1'b1);
    chk("t1_cdata", c_tdata, 16'hA014);
    step(1);
    chk("t1_cpop", c_tvalid, 1'b0);
    chk("t1_nodrop", drop_cnt, 0);

    // Back-pressure: second sequence drops both samples
    v_tready = 1'b0;
    c_tready = 1'b0;
    bfm_hi = 8'hB0;
    pulse_eos();
    step(20);
    chk("t2_vhold", v_tvalid, 1'b1);
    chk("t2_vdata", v_tdata, 16'hB01C);
    chk("t2_chold", c_tvalid, 1'b1);
    chk("t2_cdata", c_tdata, 16'hB014);
    chk("t2_drop0", drop_cnt, 0);
    step(79);
    bfm_hi = 8'hC0;
    pulse_eos();
    step(20);
    chk("t2_drop2", drop_cnt, 2);
    chk("t2_vkeep", v_tdata, 16'hB01C);
    chk("t2_ckeep", c_tdata, 16'hB014);
    chk("t2_vstill", v_tvalid, 1'b1);
    v_tready = 1'b1;
    c_tready = 1'b1;
    step(1);
    chk("t2_vpop", v_tvalid, 1'b0);
    chk("t2_cpop", c_tvalid, 1'b0);

    // Config read arriving together with EOS
    drop_cnt = 0;
    bfm_hi = 8'hD0;
    cfg_req = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = 7'h41;
    pulse_eos();
    wait_den("t3_v", 7'h1c);
    wait_den("t3_c", 7'h14);
    wait_den("t3_cfg", 7'h41);
    chk("t3_dwe", dwe, 1'b0);
    ack_seen = 1'b0;
    for (int i = 0; i < 20 && !ack_seen; i++) begin
      step(1);
      ack_seen = (cfg_ack === 1'b1);
    end
    chk("t3_ack", ack_seen, 1'b1);
    chk("t3_rdata", cfg_rdata, 16'hD041);
    cfg_req = 1'b0;
    step(1);
    chk("t3_ack_once", cfg_ack, 1'b0);
    bfm_hi = 8'hE0;
    pulse_eos();
    wait_den("t3_next", 7'h1c);
    wait_v("t3_next", 16'hE01C);

    // Config write queued behind the current read
    step(10);
    bfm_hi = 8'hF0;
    pulse_eos();
    wait_den("t4_v", 7'h1c);
    wait_den("t4_c", 7'h14);
    step(1);
    cfg_req = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 7'h40;
    cfg_wdata = 16'h1234;
    wait_den("t4_cfg", 7'h40);
    chk("t4_dwe", dwe, 1'b1);
    chk("t4_di", di, 16'h1234);
    chk("t4_cdone", c_tdata, 16'hF014);
    step(3);
    chk("t4_ack_early", cfg_ack, 1'b0);
    step(1);
    chk("t4_ack", cfg_ack, 1'b1);
    chk("t4_rdata", cfg_rdata, 16'hD041);
    cfg_req = 1'b0;
    cfg_we = 1'b0;
    step(5);
    chk("t4_nodrop", drop_cnt, 0);

    // Reset during WAIT_VOLT followed by a late drdy
    bfm_hi = 8'h11;
    pulse_eos();
    wait_den("t5_v", 7'h1c);
    step(1);
    rst = 1'b1;
    #1;
    chk_reset("t5");
    step(1);
    rst = 1'b0;
    vcount = 0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (v_tvalid === 1'b1) vcount++;
      if (den === 1'b1) dcount++;
    end
    chk("t5_no_valid", vcount, 0);
    chk("t5_no_den", dcount, 0);
    chk("t5_vdata", v_tdata, 16'h0);

`ifdef XADC_DRP_TIMEOUT_EN
    // DRP never answers: both sample reads time out
    bfm_on = 1'b0;
    drop_cnt = 0;
    pulse_eos();
    wait_den("t6_v", 7'h1c);
    step(64);
    chk("t6_nodrop_yet", drop_cnt, 0);
    wait_den("t6_c", 7'h14);
    chk("t6_drop1", drop_cnt, 1);
    step(70);
    chk("t6_drop2", drop_cnt, 2);
    chk("t6_vvalid", v_tvalid, 1'b0);
    bfm_on = 1'b1;
    bfm_hi = 8'h22;
    pulse_eos();
    wait_den("t6_idle", 7'h1c);
    wait_v("t6_recover", 16'h221C);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
